// File: rtl/scan_pkg.sv
// Shared types and constants for the two-phase scan-chain master and its bench.
// Holds the FSM state encoding, default geometry, and the per-bit cycle-cost helper.
package scan_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CAP_PHI,
        S_CAP_G1,
        S_CAP_PHIB,
        S_CAP_G2,
        S_SETUP,
        S_SH_PHI,
        S_SH_G1,
        S_SH_PHIB,
        S_TAIL,
        S_LD,
        S_LD_G,
        S_FIN
    } scan_state_e;

    localparam int DEF_CHAIN_LEN = 40;
    localparam int DEF_PH_CYC    = 2;
    localparam int DEF_GAP_CYC   = 1;

    // One shifted bit (or the capture cycle) costs two clock phases and two gaps.
    function automatic int bit_cycles(input int ph_cyc, input int gap_cyc);
        return 2 * ph_cyc + 2 * gap_cyc;
    endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// Loadable down-counter that sets how long the scan FSM dwells in each state.
// Expired is high while the count sits at zero, i.e. on the last cycle of a dwell.
module scan_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/scan_master.sv
// Two-phase scan-chain initiator: non-overlapping phi/phib/load, serial shift in/out.
// Optional readback compare against the previously written word: SCAN_MASTER_VERIFY_EN.
module scan_master
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int PH_CYC    = DEF_PH_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 CAPTURE,
    input  logic                 DO_LOAD,
    input  logic [CHAIN_LEN-1:0] WR_DATA,
    output logic [CHAIN_LEN-1:0] RD_DATA,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 phi,
    output logic                 phib,
    output logic                 scan_i0o1,
    output logic                 load,
    output logic                 scan_in,
    input  logic                 scan_out
`ifdef SCAN_MASTER_VERIFY_EN
    ,
    output logic                 MISMATCH
`endif
);

    localparam int DWELL_MAX = (PH_CYC > GAP_CYC) ? PH_CYC : GAP_CYC;
    localparam int TW        = $clog2(DWELL_MAX + 1);
    localparam int CW        = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    scan_state_e          state_reg, state_next;
    logic                 tmr_load, tmr_exp;
    logic [TW-1:0]        tmr_val;
    logic [CHAIN_LEN-1:0] sr_reg, sr_next;
    logic [CHAIN_LEN-1:0] rd_data_reg;
    logic [CW-1:0]        bit_cnt_reg;
    logic                 sample_reg;
    logic                 capture_reg, do_load_reg;
    logic                 busy_reg, done_reg;
    logic                 phi_reg, phib_reg, load_reg;
    logic                 scan_i0o1_reg, scan_in_reg;

    scan_phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (CLK),
        .srst    (RESET),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expired (tmr_exp)
    );

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        case (state_reg)
            S_IDLE: begin
                if (START) begin
                    state_next = CAPTURE ? S_CAP_PHI : S_SETUP;
                    sr_next    = WR_DATA;
                end
            end
            S_CAP_PHI:  if (tmr_exp) state_next = S_CAP_G1;
            S_CAP_G1:   if (tmr_exp) state_next = S_CAP_PHIB;
            S_CAP_PHIB: if (tmr_exp) state_next = S_CAP_G2;
            S_CAP_G2:   if (tmr_exp) state_next = S_SETUP;
            S_SETUP:    if (tmr_exp) state_next = S_SH_PHI;
            S_SH_PHI:   if (tmr_exp) state_next = S_SH_G1;
            S_SH_G1:    if (tmr_exp) state_next = S_SH_PHIB;
            S_SH_PHIB: begin
                if (tmr_exp) begin
                    sr_next    = {sr_reg[CHAIN_LEN-2:0], sample_reg};
                    state_next = (bit_cnt_reg == CW'(CHAIN_LEN - 1)) ? S_TAIL : S_SETUP;
                end
            end
            S_TAIL:     if (tmr_exp) state_next = do_load_reg ? S_LD : S_FIN;
            S_LD:       if (tmr_exp) state_next = S_LD_G;
            S_LD_G:     if (tmr_exp) state_next = S_FIN;
            S_FIN:      state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase

        // Every state change reloads the dwell timer for the state being entered.
        tmr_load = (state_next != state_reg);
        case (state_next)
            S_CAP_PHI, S_CAP_PHIB, S_SH_PHI, S_SH_PHIB, S_LD: tmr_val = TW'(PH_CYC - 1);
            default:                                         tmr_val = TW'(GAP_CYC - 1);
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= S_IDLE;
            sr_reg        <= '0;
            rd_data_reg   <= '0;
            bit_cnt_reg   <= '0;
            sample_reg    <= 1'b0;
            capture_reg   <= 1'b0;
            do_load_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            phi_reg       <= 1'b0;
            phib_reg      <= 1'b0;
            load_reg      <= 1'b0;
            scan_i0o1_reg <= 1'b0;
            scan_in_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            if (state_reg == S_IDLE && START) begin
                capture_reg <= CAPTURE;
                do_load_reg <= DO_LOAD;
                bit_cnt_reg <= '0;
            end
            if (state_reg == S_SETUP && tmr_exp) begin
                sample_reg <= scan_out;
            end
            if (state_reg == S_SH_PHIB && tmr_exp) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            // Chain-facing outputs decode the upcoming state so they come straight from flops.
            phi_reg  <= (state_next == S_CAP_PHI) || (state_next == S_SH_PHI);
            phib_reg <= (state_next == S_CAP_PHIB) || (state_next == S_SH_PHIB);
            load_reg <= (state_next == S_LD);
            done_reg <= (state_next == S_FIN);
            busy_reg <= (state_next != S_IDLE) && (state_next != S_FIN);
            // Mode stays in shift through the load pulse and drops only once all clocks are idle.
            scan_i0o1_reg <= (state_next == S_SETUP) || (state_next == S_SH_PHI) ||
                             (state_next == S_SH_G1) || (state_next == S_SH_PHIB) ||
                             (state_next == S_TAIL)  || (state_next == S_LD) ||
                             (state_next == S_LD_G);
            if (state_next == S_SETUP && state_reg != S_SETUP) begin
                scan_in_reg <= sr_next[CHAIN_LEN-1];
            end else if (state_next == S_FIN) begin
                scan_in_reg <= 1'b0;
            end
            if (state_next == S_FIN) begin
                rd_data_reg <= sr_reg;
            end
        end
    end

`ifdef SCAN_MASTER_VERIFY_EN
    logic [CHAIN_LEN-1:0] prev_reg;
    logic                 mismatch_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_reg     <= '0;
            mismatch_reg <= 1'b0;
        end else if (state_next == S_FIN) begin
            prev_reg     <= WR_DATA;
            mismatch_reg <= capture_reg ? 1'b0 : (sr_reg != prev_reg);
        end
    end

    assign MISMATCH = mismatch_reg;
`endif

    assign RD_DATA   = rd_data_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;
    assign phi       = phi_reg;
    assign phib      = phib_reg;
    assign load      = load_reg;
    assign scan_i0o1 = scan_i0o1_reg;
    assign scan_in   = scan_in_reg;

endmodule

// File: tb/tb_scan_master.sv
// Randomized bench for scan_master against an 8-cell two-phase chain model.
// Expected read data, latency and load results come from word-level bookkeeping.
module tb_scan_master;
    import scan_pkg::*;

    localparam int L   = 8;
    localparam int PH  = 2;
    localparam int GAP = 1;

    logic         clk = 1'b0;
    logic         RESET = 1'b1;
    logic         START = 1'b0;
    logic         CAPTURE = 1'b0;
    logic         DO_LOAD = 1'b0;
    logic [L-1:0] WR_DATA = '0;
    logic [L-1:0] RD_DATA;
    logic         BUSY, DONE, phi, phib, scan_i0o1, load, scan_in, scan_out;
`ifdef SCAN_MASTER_VERIFY_EN
    logic         MISMATCH;
`endif

    scan_master #(
        .CHAIN_LEN(L),
        .PH_CYC   (PH),
        .GAP_CYC  (GAP)
    ) dut (
        .CLK      (clk),
        .RESET    (RESET),
        .START    (START),
        .CAPTURE  (CAPTURE),
        .DO_LOAD  (DO_LOAD),
        .WR_DATA  (WR_DATA),
        .RD_DATA  (RD_DATA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .phi      (phi),
        .phib     (phib),
        .scan_i0o1(scan_i0o1),
        .load     (load),
        .scan_in  (scan_in),
        .scan_out (scan_out)
`ifdef SCAN_MASTER_VERIFY_EN
        ,
        .MISMATCH (MISMATCH)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural chain: master latch samples on phi, slave commits on phib, load copies out.
    logic [L-1:0] chain = '0;
    logic [L-1:0] par_in = '0;
    logic [L-1:0] par_m = '0;
    logic [L-1:0] out_latch = '0;
    logic         mode_m = 1'b0, din_m = 1'b0;
    logic         phi_q = 1'b0, phib_q = 1'b0, load_q = 1'b0, si_q = 1'b0, i0o1_q = 1'b0;
    int           phi_cnt = 0, load_cnt = 0;
    int           overlap_viol = 0, gap_viol = 0, hazard_viol = 0;

    assign scan_out = chain[L-1];

    always @(negedge clk) begin
        if ((phi && phib) || (phi && load) || (phib && load)) overlap_viol++;
        if ((phi && (phib_q || load_q)) || (phib && (phi_q || load_q)) ||
            (load && (phi_q || phib_q))) gap_viol++;
        if (((scan_in != si_q) || (scan_i0o1 != i0o1_q)) && (phi || phib || load)) hazard_viol++;
        if (phi && !phi_q) begin
            phi_cnt++;
            mode_m = scan_i0o1;
            din_m  = scan_in;
            par_m  = par_in;
        end
        if (phib && !phib_q) chain = mode_m ? {chain[L-2:0], din_m} : par_m;
        if (load && !load_q) begin
            load_cnt++;
            out_latch = chain;
        end
        phi_q  = phi;
        phib_q = phib;
        load_q = load;
        si_q   = scan_in;
        i0o1_q = scan_i0o1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [L-1:0] chain_word = '0;  // what the chain holds, as the host understands it
    logic [L-1:0] last_wr = '0;     // last word written, for readback compare

    task automatic run_txn(input logic [L-1:0] wr, input logic cap, input logic ld,
                           input logic [L-1:0] par, input logic stress);
        int           exp_n, done_at, k, phi0, load0, extra;
        logic [L-1:0] exp_rd, latch0;
        logic         exp_mm;
        exp_rd = cap ? par : chain_word;
        exp_mm = cap ? 1'b0 : (chain_word != last_wr);
        exp_n  = (cap ? bit_cycles(PH, GAP) : 0) + L * bit_cycles(PH, GAP) + GAP +
                 (ld ? PH + GAP : 0);
        phi0    = phi_cnt;
        load0   = load_cnt;
        latch0  = out_latch;
        par_in  = par;
        WR_DATA = wr;
        CAPTURE = cap;
        DO_LOAD = ld;
        START   = 1'b1;
        done_at = 0;
        k       = 0;
        while (k < 400 && done_at == 0) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) check("busy_start", 64'(BUSY), 64'(1));
            if (DONE) done_at = k;
            START = stress && BUSY;
        end
        START = 1'b0;
        check("done_latency", 64'(done_at), 64'(exp_n + 1));
        check("rd_data", 64'(RD_DATA), 64'(exp_rd));
        check("busy_at_done", 64'(BUSY), 64'(0));
        check("phi_pulses", 64'(phi_cnt - phi0), 64'(L + (cap ? 1 : 0)));
        check("load_pulses", 64'(load_cnt - load0), 64'(ld ? 1 : 0));
        check("out_latch", 64'(out_latch), 64'(ld ? wr : latch0));
`ifdef SCAN_MASTER_VERIFY_EN
        check("mismatch", 64'(MISMATCH), 64'(exp_mm));
`endif
        extra = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (DONE) extra++;
        end
        check("extra_done", 64'(extra), 64'(0));
        check("rd_hold", 64'(RD_DATA), 64'(exp_rd));
        $display("txn wr=%02h cap=%0d ld=%0d par=%02h stress=%0d -> rd=%02h done_at=%0d",
                 wr, cap, ld, par, stress, RD_DATA, done_at);
        chain_word = wr;
        last_wr    = wr;
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, 64'({BUSY, DONE, phi, phib, load, scan_in, scan_i0o1}), 64'(0));
        check({tag, "_rd"}, 64'(RD_DATA), 64'(0));
`ifdef SCAN_MASTER_VERIFY_EN
        check({tag, "_mm"}, 64'(MISMATCH), 64'(0));
`endif
    endtask

    initial begin
        int           dones;
        logic [L-1:0] w, p;
        logic         c, d;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        RESET = 1'b0;
        @(posedge clk);
        #1;

        run_txn(8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);
        run_txn(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
        run_txn(8'h77, 1'b1, 1'b0, 8'h5E, 1'b0);

        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            p = 8'($urandom);
            c = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            run_txn(w, c, d, p, 1'b0);
        end

        run_txn(8'($urandom), 1'b0, 1'b1, 8'h00, 1'b1);

        // Abort a transaction partway through.
        WR_DATA = 8'h96;
        CAPTURE = 1'b0;
        DO_LOAD = 1'b1;
        START   = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        RESET = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("abort_reset");
        RESET = 1'b0;
        dones = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (DONE) dones++;
        end
        check("abort_no_done", 64'(dones), 64'(0));
        check("abort_rd", 64'(RD_DATA), 64'(0));
        last_wr = '0;
        $display("abort: reset at cycle 20, dones after=%0d rd=%02h", dones, RD_DATA);

        run_txn(8'hC3, 1'b1, 1'b1, 8'($urandom), 1'b0);
        run_txn(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);

        check("overlap_viol", 64'(overlap_viol), 64'(0));
        check("gap_viol", 64'(gap_viol), 64'(0));
        check("hazard_viol", 64'(hazard_viol), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
